l1_writeback_cache: RTL
=======================

Name: l1_writeback_cache

Overview:
- Direct-mapped, write-back, write-allocate cache between the CPU datapath's 16-bit memory port and the 128-bit line-based physical memory.
- Serves word reads and byte-enabled writes on hits with zero added wait cycles.
- On a miss it writes back a dirty victim line, fetches the missing line, then completes the request.
- It is the sole master of the physical memory read/write/resp handshake.

Parameters:
- NUM_SETS, 8, number of cache lines (power of two, ≥2); set index width S = log2(NUM_SETS).
- LINE_BITS, 128, line width in bits, fixed to the physical memory line; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_byte_enable  in  2  write byte enables; bit0 = bits[7:0], bit1 = bits[15:8].
- mem_address  in  16  CPU byte address; bit0 ignored.
- mem_wdata  in  16  CPU write data.
- mem_resp  out  1  one-cycle completion pulse to the CPU.
- mem_rdata  out  16  read data, valid while mem_resp = 1.
- pmem_read  out  1  line read request to physical memory.
- pmem_write  out  1  line write request to physical memory.
- pmem_address  out  16  line address; bits[3:0] always 0.
- pmem_wdata  out  128  victim line data.
- pmem_resp  in  1  physical memory completion pulse.
- pmem_rdata  in  128  fetched line, valid while pmem_resp = 1.

Behaviour:
- Address split:
  - word = addr[3:1]
  - index = addr[3+S:4]
  - tag = addr[15:4+S] (9 bits at default)
  - Word w occupies line bits [16w+15:16w].
- Per-line state: valid, dirty, tag, 128-bit data.
- Reset:
  - Clears all valid and dirty bits; state = CHECK.
  - mem_resp, pmem_read, pmem_write = 0 immediately.
  - mem_rdata, pmem_address, pmem_wdata = 0.
  - Data and tag arrays are not reset.
- CHECK:
  - Hit = request active && valid[index] && tag match; evaluated combinationally.
  - On hit, mem_resp = 1 in the same cycle and mem_rdata = the addressed word.
  - A write hit merges enabled bytes into the line at that clock edge and sets dirty.
  - mem_byte_enable = 00 responds without modifying data or dirty.
  - If mem_read and mem_write are both high, the request is treated as a write.
  - Miss with valid && dirty victim → WRITEBACK; otherwise → ALLOCATE.
  - No request → stay in CHECK, all outputs 0.
- WRITEBACK:
  - pmem_write = 1, pmem_address = {victim tag, index, 4'h0}, pmem_wdata = victim line; all held stable.
  - On the edge where pmem_resp = 1: clear dirty, → ALLOCATE.
- ALLOCATE:
  - pmem_read = 1, pmem_address = {request tag, index, 4'h0}, held stable.
  - On the edge where pmem_resp = 1: load pmem_rdata, set tag, valid = 1, dirty = 0, → CHECK. The request then hits in CHECK.
- pmem_read and pmem_write are never both 1. Each is deasserted in the cycle after the pmem_resp cycle.
- mem_resp is never asserted outside CHECK.
- Latency:
  - Hit: 0 cycles (resp in the request cycle).
  - Clean miss: tA + 1 cycles.
  - Dirty miss: tW + tA + 1 cycles, where tX = cycles from pmem request to pmem_resp inclusive.
- The CPU must hold address, data and enables stable until mem_resp. Changes mid-miss are unsupported.
- Reset mid-WRITEBACK or mid-ALLOCATE aborts at once. Any pmem_resp after reset deasserts is ignored while in CHECK with no request.

Test Plan:
- Reset, then read 0x0012 with memory line 0x0010 = words 0..7 = 0x1110..0x1117 → one pmem_read with pmem_address 0x0010, then mem_resp with mem_rdata 0x1111; no pmem_write.
- Repeat read 0x0012 → mem_resp in the request cycle with mem_rdata 0x1111, no pmem activity.
- Write 0x0012, data 0xABCD, byte_enable 2'b10 → immediate mem_resp; a following read of 0x0012 returns 0xAB11.
- Read 0x0092 (same index 1, tag 1) → pmem_write of line 0x0010 with word1 = 0xAB11 first, then pmem_read of 0x0090, then mem_resp with the memory's word1 of 0x0090.
- Write with byte_enable 2'b00 on a hit, then evict that line → mem_resp returned; the line stays clean, so no pmem_write occurs on eviction.
- Assert reset while pmem_read is high during an allocate → pmem_read drops asynchronously. The next read of the same address misses again and issues a fresh pmem_read.

Source files
------------

// File: rtl/l1_writeback_cache_if.sv
// CPU word port and physical-memory line port of the L1 write-back cache.
// master = CPU/memory environment, slave = the cache.
interface l1_writeback_cache_if;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output pmem_resp, pmem_rdata,
        input  mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  pmem_resp, pmem_rdata,
        output mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/l1_writeback_cache.sv
// Direct-mapped write-back, write-allocate L1 cache: 16-bit CPU word port in front of a
// 128-bit line memory. Hits complete combinationally; misses write back then allocate.
module l1_writeback_cache #(
    parameter int unsigned NUM_SETS  = 8,
    parameter int unsigned LINE_BITS = 128
) (
    input logic                 clk,
    input logic                 reset,
    l1_writeback_cache_if.slave bus
);
    localparam int unsigned S     = $clog2(NUM_SETS);
    localparam int unsigned TAG_W = 12 - S;

    typedef enum logic [1:0] {StCheck, StWriteback, StAllocate} state_e;

    state_e               state_q, state_d;
    logic [NUM_SETS-1:0]  valid_q, valid_d;
    logic [NUM_SETS-1:0]  dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_SETS];
    logic [LINE_BITS-1:0] data_q [NUM_SETS];

    logic [2:0]           word;
    logic [S-1:0]         idx;
    logic [TAG_W-1:0]     tag;
    logic                 unused_addr_bit;
    logic                 req, is_write, hit;
    logic [LINE_BITS-1:0] cur_line, line_d;
    logic                 line_we, tag_we;

    assign word            = bus.mem_address[3:1];
    assign idx             = bus.mem_address[3+S:4];
    assign tag             = bus.mem_address[15:4+S];
    assign unused_addr_bit = bus.mem_address[0];

    assign req      = bus.mem_read | bus.mem_write;
    assign is_write = bus.mem_write;
    assign cur_line = data_q[idx];
    assign hit      = req && valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d          = state_q;
        valid_d          = valid_q;
        dirty_d          = dirty_q;
        line_we          = 1'b0;
        tag_we           = 1'b0;
        line_d           = cur_line;
        bus.mem_resp     = 1'b0;
        bus.mem_rdata    = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;

        unique case (state_q)
            StCheck: begin
                if (hit) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = cur_line[{word, 4'd0} +: 16];
                    // An all-zero byte enable completes without touching data or dirty.
                    if (is_write && (bus.mem_byte_enable != 2'b00)) begin
                        line_we = 1'b1;
                        if (bus.mem_byte_enable[0]) line_d[{word, 4'd0} +: 8] = bus.mem_wdata[7:0];
                        if (bus.mem_byte_enable[1]) line_d[{word, 4'd8} +: 8] = bus.mem_wdata[15:8];
                        dirty_d[idx] = 1'b1;
                    end
                end else if (req) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
                end
            end
            StWriteback: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[idx], idx, 4'h0};
                bus.pmem_wdata   = cur_line;
                if (bus.pmem_resp) begin
                    dirty_d[idx] = 1'b0;
                    state_d      = StAllocate;
                end
            end
            StAllocate: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {tag, idx, 4'h0};
                if (bus.pmem_resp) begin
                    line_we      = 1'b1;
                    tag_we       = 1'b1;
                    line_d       = bus.pmem_rdata;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = StCheck;
                end
            end
            default: state_d = StCheck;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StCheck;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (line_we) data_q[idx] <= line_d;
        if (tag_we)  tag_q[idx]  <= tag;
    end
endmodule
